ifetch_unit: RTL and testbench

//  Instruction fetch stage fed by the PC register. Samples the current PC,

---
 rtl/ifetch_unit_pkg.sv | 22 ++
 rtl/ifetch_unit_if.sv | 29 ++
 rtl/ifetch_unit_fifo.sv | 73 +++++++
 rtl/ifetch_unit.sv | 123 ++++++++++++
 tb/tb_ifetch_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-pipeline types: queue entry layout, fetch FSM states and the
// canonical NOP encoding used to initialise empty queue slots.
package ifetch_unit_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/grant/response bus. The fetch unit is the
// master; the memory (or its model) is the slave.
interface ifetch_unit_if #(
  parameter int WIDTH = 32
);

  logic             imem_req_out;
  logic [WIDTH-1:0] imem_addr_out;
  logic             imem_gnt_in;
  logic             imem_rvalid_in;
  logic [WIDTH-1:0] imem_rdata_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_gnt_in,
    input  imem_rvalid_in,
    input  imem_rdata_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_gnt_in,
    output imem_rvalid_in,
    output imem_rdata_in
  );

endinterface

// File: rtl/ifetch_unit_fifo.sv
// Small fetch queue of {pc, instr} entries. Head is read combinationally,
// clear has priority over push/pop, pointers wrap naturally (DEPTH is a
// power of two).
module fetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_in,
  input  logic                     pop_in,
  input  logic                     clear_in,
  input  fetch_entry_t             data_in,
  output fetch_entry_t             head_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_slots [DEPTH];

  assign empty_out = (r_count == '0);
  assign count_out = r_count;
  // A clear wins over anything else in the same cycle.
  assign w_push    = push_in && !clear_in;
  assign w_pop     = pop_in && !empty_out && !clear_in;
  assign head_out  = w_slots[r_rd_ptr];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    fetch_entry_t r_entry;

    // Slot captures the incoming entry when the write pointer points at it.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_entry <= '{pc: '0, instr: INSTR_NOP};
      end else if (w_push && (r_wr_ptr == AW'(gi))) begin
        r_entry <= data_in;
      end
    end

    assign w_slots[gi] = r_entry;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: samples the PC, performs one word read at a time
// over the request/grant/response bus and queues {pc, instr} for decode.
// stall_out tells the PC register to hold whenever a new PC cannot be taken.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   pc_in,
  input  logic               flush_in,
  output logic               stall_out,
  ifetch_unit_if.master      imem,
  output logic               instr_valid_out,
  output logic [WIDTH-1:0]   instr_out,
  output logic [WIDTH-1:0]   instr_pc_out,
  input  logic               decode_ready_in
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_pc;
  logic             r_flush_seen;
  logic             w_flush_seen_next;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  assign imem.imem_req_out  = (r_state == REQ);
  assign imem.imem_addr_out = r_addr;

  assign w_push_entry    = '{pc: r_pc, instr: imem.imem_rdata_in};
  assign instr_valid_out = !w_empty;
  assign instr_out       = instr_valid_out ? w_head.instr : '0;
  assign instr_pc_out    = instr_valid_out ? w_head.pc    : '0;
  assign w_pop           = instr_valid_out && decode_ready_in;

  // Next-state, accept/push decisions and PC-register stall.
  always_comb begin
    w_state_next      = r_state;
    w_flush_seen_next = r_flush_seen;
    w_accept          = 1'b0;
    w_push            = 1'b0;
    stall_out         = 1'b1;
    case (r_state)
      IDLE: begin
        // Queue space is reserved here, so the later push can never overflow.
        w_accept  = !flush_in && (w_count < CW'(DEPTH));
        stall_out = !w_accept;
        if (w_accept) begin
          w_state_next      = REQ;
          w_flush_seen_next = 1'b0;
        end
      end
      REQ: begin
        // The request stays up until granted; a flush only marks the
        // eventual response for discard.
        if (imem.imem_gnt_in) begin
          w_state_next = (flush_in || r_flush_seen) ? DROP : WAIT;
        end else if (flush_in) begin
          w_flush_seen_next = 1'b1;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid_in) begin
          w_push       = !flush_in;
          w_state_next = IDLE;
        end else if (flush_in) begin
          w_state_next = DROP;
        end
      end
      DROP: begin
        if (imem.imem_rvalid_in) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, fetch address and fetch PC registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_pc         <= '0;
      r_flush_seen <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_flush_seen <= w_flush_seen_next;
      if (w_accept) begin
        r_addr <= {pc_in[WIDTH-1:2], 2'b00};
        r_pc   <= pc_in;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (w_push),
    .pop_in    (w_pop),
    .clear_in  (flush_in),
    .data_in   (w_push_entry),
    .head_out  (w_head),
    .empty_out (w_empty),
    .count_out (w_count)
  );

  // A response is only legal while a granted read is outstanding.
  a_no_stray_rvalid: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(imem.imem_rvalid_in && (r_state == IDLE || r_state == REQ)));

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios followed by random traffic,
// checked against a transaction-level model of the fetch queue and the
// single outstanding memory read.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int DEPTH = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic        flush_in = 1'b0;
  logic        decode_ready_in = 1'b0;
  logic        stall_out;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;

  ifetch_unit_if #(.WIDTH(32)) imem_bus ();

  ifetch_unit #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pc_in           (pc_in),
    .flush_in        (flush_in),
    .stall_out       (stall_out),
    .imem            (imem_bus),
    .instr_valid_out (instr_valid_out),
    .instr_out       (instr_out),
    .instr_pc_out    (instr_pc_out),
    .decode_ready_in (decode_ready_in)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  // Model: contents of the decode queue, and the one outstanding fetch.
  fetch_entry_t exp_q[$];
  int          ph = 0;          // 0 no fetch, 1 awaiting grant, 2 awaiting data
  int          gcnt = 0;
  int          rcnt = 0;
  bit          flushed = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] pc_reg = '0;

  // Stimulus knobs (-1 = random).
  int          gnt_dly = -1;
  int          rv_dly = -1;
  bit          data_fix = 0;
  logic [31:0] data_val = '0;
  bit          force_rv = 0;

  // Expectations for the cycle currently being driven.
  logic        exp_stall = 1'b0;
  logic        exp_req = 1'b0;
  bit          last_acc = 0;
  bit          check_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic cycle(input logic f, input logic rd, input logic [31:0] pc);
    logic        acc;
    logic        g;
    logic        rv;
    logic [31:0] d;
    flush_in        = f;
    decode_ready_in = rd;
    pc_in           = pc;
    g  = (ph == 1 && gcnt == 0);
    rv = (ph == 2 && rcnt == 0);
    d  = data_fix ? data_val : $urandom;
    imem_bus.imem_gnt_in    = g;
    imem_bus.imem_rvalid_in = rv || force_rv;
    imem_bus.imem_rdata_in  = d;
    acc       = (ph == 0) && !f && (exp_q.size() < DEPTH);
    exp_stall = !acc;
    exp_req   = (ph == 1);
    last_acc  = acc && rst_in;
    @(posedge clk_in);
    if (rst_in) begin
      if (f) begin
        exp_q.delete();
      end else begin
        if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
        if (rv && !flushed) exp_q.push_back('{pc: m_pc, instr: d});
      end
      case (ph)
        0: if (acc) begin
          ph      = 1;
          m_pc    = pc;
          m_addr  = {pc[31:2], 2'b00};
          flushed = 0;
          gcnt    = (gnt_dly >= 0) ? gnt_dly : int'($urandom_range(0, 3));
        end
        1: begin
          if (f) flushed = 1;
          if (g) begin
            ph   = 2;
            rcnt = (rv_dly >= 0) ? rv_dly : int'($urandom_range(0, 2));
          end else begin
            gcnt--;
          end
        end
        default: begin
          if (f) flushed = 1;
          if (rv) ph = 0;
          else rcnt--;
        end
      endcase
    end
    #1;
  endtask

  // PC register behaviour: advance on accept, jump on flush.
  task automatic run(input int n, input int flush_pct, input int ready_pct, input bit rand_pc);
    logic f;
    logic rd;
    for (int i = 0; i < n; i++) begin
      f  = ($urandom_range(0, 99) < flush_pct);
      rd = ($urandom_range(0, 99) < ready_pct);
      cycle(f, rd, pc_reg);
      if (f) pc_reg = rand_pc ? $urandom : pc_reg + 32'h40;
      else if (last_acc) pc_reg = rand_pc ? $urandom : pc_reg + 32'h4;
    end
  endtask

  // Flush until no fetch is outstanding, then once more in the idle state.
  task automatic settle();
    for (int i = 0; i < 20 && ph != 0; i++) cycle(1'b1, 1'b1, pc_reg);
    cycle(1'b1, 1'b1, pc_reg);
  endtask

  // Monitor: compares DUT outputs to the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk_in);
      if (check_on) begin
        chk("stall", {31'd0, stall_out}, {31'd0, exp_stall});
        chk("req", {31'd0, imem_bus.imem_req_out}, {31'd0, exp_req});
        if (exp_req) chk("addr", imem_bus.imem_addr_out, m_addr);
        chk("valid", {31'd0, instr_valid_out}, {31'd0, exp_q.size() != 0});
        if (instr_valid_out && decode_ready_in && !flush_in && exp_q.size() != 0) begin
          chk("head_pc", instr_pc_out, exp_q[0].pc);
          chk("head_instr", instr_out, exp_q[0].instr);
          $display("pop pc=%h instr=%h", instr_pc_out, instr_out);
        end
        if (!rst_in) begin
          chk("rst_addr", imem_bus.imem_addr_out, 32'h0);
          chk("rst_instr", instr_out, 32'h0);
          chk("rst_pc", instr_pc_out, 32'h0);
        end
      end
    end
  end

  initial begin
    imem_bus.imem_gnt_in    = 1'b0;
    imem_bus.imem_rvalid_in = 1'b0;
    imem_bus.imem_rdata_in  = '0;
    check_on = 1;
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    rst_in = 1'b1;

    // 1: basic latency with fixed data.
    gnt_dly = 0; rv_dly = 0; data_fix = 1; data_val = 32'hDEADBEEF;
    cycle(1'b0, 1'b1, 32'h100);
    repeat (4) cycle(1'b0, 1'b1, 32'h100);
    data_fix = 0;

    // 2: decode stalled, queue fills, then drains in order.
    settle();
    pc_reg = 32'h0;
    run(12, 0, 0, 0);
    run(8, 0, 100, 0);

    // 3: grant delayed by four cycles.
    settle();
    gnt_dly = 4;
    run(14, 0, 100, 0);

    // 4: flush in WAIT, response two cycles later, then redirect to 0x200.
    gnt_dly = 0; rv_dly = 2;
    settle();
    cycle(1'b0, 1'b1, 32'h180);
    cycle(1'b0, 1'b1, 32'h180);
    cycle(1'b1, 1'b1, 32'h200);
    cycle(1'b0, 1'b1, 32'h200);
    cycle(1'b0, 1'b1, 32'h200);
    pc_reg = 32'h200;
    run(8, 0, 100, 0);

    // 5: full queue, pop and flush together.
    rv_dly = 0;
    settle();
    run(10, 0, 0, 0);
    cycle(1'b1, 1'b1, pc_reg);
    run(6, 0, 0, 0);

    // 6: reset during WAIT with a late response during reset.
    settle();
    rv_dly = 1;
    cycle(1'b0, 1'b1, 32'h300);
    cycle(1'b0, 1'b1, 32'h300);
    rst_in = 1'b0;
    ph = 0; flushed = 0; m_addr = '0; exp_q.delete();
    force_rv = 1;
    cycle(1'b0, 1'b1, 32'h300);
    cycle(1'b0, 1'b1, 32'h300);
    force_rv = 0;
    cycle(1'b0, 1'b1, 32'h300);
    rst_in = 1'b1;

    // Random traffic.
    gnt_dly = -1; rv_dly = -1;
    run(1500, 5, 70, 1);

    check_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
